// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: FSM encoding and default timing.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_CLK_HZ       = 50_000_000;
  localparam int unsigned DEF_TICK_HZ      = 1_000;
  localparam int unsigned DEF_STABLE_TICKS = 20;
  localparam int unsigned DEF_LONG_TICKS   = 1_000;
  localparam int unsigned DEF_TICK_DIV     = DEF_CLK_HZ / DEF_TICK_HZ;

endpackage

// File: rtl/btn_debounce_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as a tick.
module tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q;

  // Wrap-around sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + W'(1);
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronizer, tick-sampled qualification FSM, and
// registered press / release / long-hold pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HW  = $clog2(LONG_TICKS + 1);

  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);
  localparam logic [HW-1:0] STABLE_H = HW'(STABLE_TICKS);
  localparam logic [HW-1:0] LONG_H   = HW'(LONG_TICKS);

  logic          sync1_q;
  logic          sync_in;
  logic          tick;

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_fired_q, long_fired_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync_in <= sync1_q;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      rel_q        <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      rel_q        <= rel_d;
      long_q       <= long_d;
    end
  end

  // Next-state and next-output logic; pulses are computed one cycle ahead
  // so the output flops present them on the cycle of the state change.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    rel_d        = 1'b0;
    long_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync_in) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!sync_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == STABLE_C - CW'(1)) begin
            state_d = PRESSED;
            cnt_d   = '0;
            hold_d  = STABLE_H;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      PRESSED: begin
        if (!sync_in) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          if ((hold_q == LONG_H) && !long_fired_q) begin
            long_d       = 1'b1;
            long_fired_d = 1'b1;
          end
          if (tick && (hold_q != LONG_H)) begin
            hold_d = hold_q + HW'(1);
          end
        end
      end

      RELEASE_WAIT: begin
        if (sync_in) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == STABLE_C - CW'(1)) begin
            state_d      = IDLE;
            cnt_d        = '0;
            hold_d       = '0;
            long_fired_d = 1'b0;
            level_d      = 1'b0;
            rel_d        = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

  // Each pulse comes from a distinct state transition, so at most one is high.
  a_pulse_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0({press_q, rel_q, long_q})
  );

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DIV=10, STABLE_TICKS=3, LONG_TICKS=8.
module tb_btn_debounce;
  import btn_pkg::*;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  int checks   = 0;
  int failures = 0;

  btn_debounce #(
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .STABLE_TICKS (3),
    .LONG_TICKS   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One segment: hold rst_n/btn_in for 'cycles' clocks, count pulses seen,
  // and check the level at the end of the segment.
  typedef struct {
    logic  rst_n;
    logic  btn;
    int    cycles;
    int    press;
    int    rel;
    int    lng;
    logic  level;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input int n, input int p,
                     input int rl, input int lg, input logic lv, input string nm);
    vec_t v;
    v.rst_n = r; v.btn = b; v.cycles = n; v.press = p; v.rel = rl;
    v.lng = lg; v.level = lv; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  initial begin
    int np, nr, nl, ov;

    rst_n  = 1'b0;
    btn_in = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Hand sequence: reset state, first tick timing, IDLE->PRESS_WAIT latency.
    check("rst_state",   int'(dut.state_q), int'(IDLE));
    check("rst_outputs", int'({btn_level, press_pulse, release_pulse, long_pulse}), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 10) check($sformatf("tick_e%0d", k), int'(dut.tick), (k == 9) ? 1 : 0);
      if (k == 2)  check("state_e2", int'(dut.state_q), int'(IDLE));
      if (k == 3)  check("state_e3", int'(dut.state_q), int'(PRESS_WAIT));
      if (k == 29) check("press_e29", int'(press_pulse), 0);
      if (k == 30) check("press_e30", int'(press_pulse), 1);
    end
    // Hand sequence: asynchronous reset mid-cycle while pressed.
    check("level_before_rst", int'(btn_level), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", int'(btn_level), 0);
    check("async_rst_state", int'(dut.state_q), int'(IDLE));
    @(negedge clk);

    // Scenario A: clean press, long hold, release.
    add(0, 1,  3, 0, 0, 0, 0, "A_rst");
    add(1, 1, 29, 0, 0, 0, 0, "A_qual");
    add(1, 1,  1, 1, 0, 0, 1, "A_press");
    add(1, 1, 50, 0, 0, 0, 1, "A_hold");
    add(1, 1,  1, 0, 0, 1, 1, "A_long");
    add(1, 1, 19, 0, 0, 0, 1, "A_norepeat");
    add(1, 0, 29, 0, 0, 0, 1, "A_relqual");
    add(1, 0,  1, 0, 1, 0, 0, "A_release");
    add(1, 0, 20, 0, 0, 0, 0, "A_idle");
    // Scenario B: press bounce restarts qualification.
    add(0, 0,  3, 0, 0, 0, 0, "B_rst");
    add(1, 0,  5, 0, 0, 0, 0, "B_low");
    add(1, 1, 12, 0, 0, 0, 0, "B_bounce_hi");
    add(1, 0,  3, 0, 0, 0, 0, "B_bounce_lo");
    add(1, 1, 29, 0, 0, 0, 0, "B_requal");
    add(1, 1,  1, 1, 0, 0, 1, "B_press");
    add(1, 1, 10, 0, 0, 0, 1, "B_held");
    // Scenario C: release glitch at hold tick 6 keeps the press alive.
    add(0, 1,  3, 0, 0, 0, 0, "C_rst");
    add(1, 1, 29, 0, 0, 0, 0, "C_qual");
    add(1, 1,  1, 1, 0, 0, 1, "C_press");
    add(1, 1, 30, 0, 0, 0, 1, "C_hold6");
    add(1, 0,  4, 0, 0, 0, 1, "C_glitch");
    add(1, 1, 16, 0, 0, 0, 1, "C_hold8");
    add(1, 1,  1, 0, 0, 1, 1, "C_long");
    add(1, 1, 30, 0, 0, 0, 1, "C_norepeat");
    add(1, 0, 40, 0, 1, 0, 0, "C_release");
    // Scenario D: reset during qualification and during a press.
    add(0, 1,  3, 0, 0, 0, 0, "D_rst");
    add(1, 1, 24, 0, 0, 0, 0, "D_cnt2");
    add(0, 1,  2, 0, 0, 0, 0, "D_rst_mid");
    add(1, 1, 29, 0, 0, 0, 0, "D_requal");
    add(1, 1,  1, 1, 0, 0, 1, "D_press");
    add(1, 1, 10, 0, 0, 0, 1, "D_held");
    add(0, 0,  2, 0, 0, 0, 0, "D_rst_press");
    add(1, 0, 20, 0, 0, 0, 0, "D_after");

    foreach (vecs[i]) begin
      rst_n  = vecs[i].rst_n;
      btn_in = vecs[i].btn;
      np = 0; nr = 0; nl = 0; ov = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(posedge clk);
        @(negedge clk);
        np += int'(press_pulse);
        nr += int'(release_pulse);
        nl += int'(long_pulse);
        if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1) ov++;
      end
      check({vecs[i].name, ".press"},   np, vecs[i].press);
      check({vecs[i].name, ".release"}, nr, vecs[i].rel);
      check({vecs[i].name, ".long"},    nl, vecs[i].lng);
      check({vecs[i].name, ".level"},   int'(btn_level), int'(vecs[i].level));
      check({vecs[i].name, ".overlap"}, ov, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
